redirect_sequencer: RTL and testbench
=====================================

# redirect_sequencer

Single owner of every PC redirect request in the IF stage; sits between the EX-stage branch resolver, the trap unit and the FENCE.I logic on one side and the PC controller's branch/trap/flush inputs on the other. Arbitrates simultaneous redirect sources by age and priority and holds a redirect captured during a stall until it can be issued. Generates a fixed-length flush window after each issued redirect and sequences FENCE.I: drain, I-cache invalidate, refetch.

## Interface
- XLEN, 32, address width
- FLUSH_CYCLES, 2, cycles `o_flush` stays high after an issued redirect (1..7)
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous, active-low reset
- i_stall  in  1  pipeline stall; a redirect must not be issued while high
- i_trap_req / i_mret_req  in  1  trap / MRET request, single-cycle pulse
- i_trap_target  in  XLEN  trap or MRET target, valid with the request
- i_branch_req  in  1  EX mispredict/jump redirect, single-cycle pulse
- i_branch_target  in  XLEN  redirect target
- i_fencei_valid  in  1  FENCE.I request, held until `o_fencei_ack`
- i_fencei_pc  in  XLEN  PC of the FENCE.I instruction
- i_pipe_empty  in  1  no older instructions in flight beyond EX
- i_icache_inv_done  in  1  invalidate-complete pulse
- o_trap_taken / o_mret_taken  out  1  issue strobes to the PC controller
- o_trap_target  out  XLEN  target for trap/MRET
- o_branch_taken  out  1  branch/FENCE.I redirect strobe
- o_branch_target  out  XLEN  target for branch/FENCE.I
- o_flush  out  1  flush window active
- o_icache_inv  out  1  single-cycle invalidate request
- o_fencei_ack  out  1  single-cycle FENCE.I completion
- o_busy  out  1  state != IDLE or flush window active

## Operation
- States: IDLE, HOLD, FENCE_DRAIN, FENCE_INV, FENCE_REDIR.
- Priority within a cycle: trap > mret > branch > fence. A lower-priority request is dropped in the same cycle; the older instruction wins.
- IDLE with `i_stall`=0: the winning trap/mret/branch is passed through combinationally to the matching strobe and target. The flush counter loads FLUSH_CYCLES.
- IDLE with `i_stall`=1 and a request present: the kind and target are captured, and the state moves to HOLD.
- HOLD: the captured redirect is issued from registers on the first cycle with `i_stall`=0, then the state returns to IDLE.
  - A new trap/mret arriving in HOLD overwrites a held branch.
  - A new branch never overwrites a held trap/mret.
  - A new request in the issue cycle follows the same priority rules against the held one.
- FENCE.I is accepted only in IDLE with no other request present and the flush window inactive:
  - FENCE_DRAIN: wait for `i_pipe_empty`.
  - FENCE_INV: pulse `o_icache_inv` on entry, then wait for `i_icache_inv_done`.
  - FENCE_REDIR: issue `o_branch_taken` with target `i_fencei_pc + 4` (mod 2^XLEN) when not stalled, pulse `o_fencei_ack`, return to IDLE.
- A trap/mret during any FENCE_* state aborts the fence:
  - The trap is issued (or held if stalled).
  - `o_fencei_ack` is not pulsed.
  - The requester keeps `i_fencei_valid` and is re-accepted later.
- A branch request during FENCE_* is ignored.
- Flush counter: 3 bits, decrements to 0, `o_flush` = (count != 0). It reloads on every issued redirect, including one issued inside the window.

## Timing
- Reset: state IDLE, counter 0, held registers 0. All strobes, `o_flush`, `o_icache_inv`, `o_fencei_ack` and `o_busy` are 0; targets are 0.
- Pass-through latency is 0 cycles: request and strobe appear in the same cycle.
- Replay from HOLD is issued in the cycle `i_stall` falls.
- `o_flush` rises the cycle after issue and lasts exactly FLUSH_CYCLES cycles.
- Strobes are mutually exclusive and never high while `i_stall`=1.
- Reset mid-operation discards any held redirect and any fence in progress without ack.

## Structure
- Shared IF package: `redirect_kind_e` (NONE, TRAP, MRET, BRANCH, FENCE) and `redir_state_e`.
- One sub-module, `flush_window_counter` (load, decrement, active flag).

## Test plan
- Branch to 0x100 with no stall -> `o_branch_taken`=1 with target 0x100 in the same cycle; `o_flush` high for exactly 2 cycles.
- Trap to 0x80 and branch to 0x200 in the same cycle -> only `o_trap_taken`, target 0x80.
- Branch to 0x300 while stalled 3 cycles, then trap to 0x80 in stall cycle 2 -> on stall release, only `o_trap_taken` with 0x80.
- FENCE.I at pc 0x1000:
  - `i_pipe_empty` after 4 cycles -> `o_icache_inv` pulse.
  - `inv_done` 5 cycles later -> branch to 0x1004 and `o_fencei_ack` in the same cycle.
- Trap during FENCE_INV -> trap issued, no ack; re-accepted after the flush window.
- `i_rst_n`=0 while in HOLD -> next cycle all outputs 0 and no replay after stall drops.

Source files
------------

// File: rtl/redirect_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : redirect_sequencer_pkg                                     |
// | Description : Shared IF-stage types for the redirect sequencer:          |
// |               redirect kinds, FSM states, flush counter width and a      |
// |               helper to classify trap-class redirects.                   |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package redirect_sequencer_pkg;

    localparam int c_FLUSH_CNT_W = 3;

    typedef enum logic [2:0] {
        K_NONE   = 3'd0,
        K_TRAP   = 3'd1,
        K_MRET   = 3'd2,
        K_BRANCH = 3'd3,
        K_FENCE  = 3'd4
    } redirect_kind_e;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_HOLD        = 3'd1,
        S_FENCE_DRAIN = 3'd2,
        S_FENCE_INV   = 3'd3,
        S_FENCE_REDIR = 3'd4
    } redir_state_e;

    // Trap and MRET share the trap target path and outrank branches.
    function automatic logic is_trap_kind(input redirect_kind_e k);
        return (k == K_TRAP) || (k == K_MRET);
    endfunction

endpackage
`default_nettype wire

// File: rtl/redirect_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : redirect_sequencer_if                                      |
// | Description : Request/issue bundle between the redirect sources, the     |
// |               sequencer and the PC controller. Signal directions are     |
// |               named from the sequencer's point of view.                  |
// | Modports    : slave  - the sequencer (takes i_*, drives o_*)             |
// |               master - the surrounding pipeline (drives i_*)             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface redirect_sequencer_if #(
    parameter int XLEN = 32
);
    logic            i_stall;
    logic            i_trap_req;
    logic            i_mret_req;
    logic [XLEN-1:0] i_trap_target;
    logic            i_branch_req;
    logic [XLEN-1:0] i_branch_target;
    logic            i_fencei_valid;
    logic [XLEN-1:0] i_fencei_pc;
    logic            i_pipe_empty;
    logic            i_icache_inv_done;

    logic            o_trap_taken;
    logic            o_mret_taken;
    logic [XLEN-1:0] o_trap_target;
    logic            o_branch_taken;
    logic [XLEN-1:0] o_branch_target;
    logic            o_flush;
    logic            o_icache_inv;
    logic            o_fencei_ack;
    logic            o_busy;

    modport slave (
        input  i_stall, i_trap_req, i_mret_req, i_trap_target,
               i_branch_req, i_branch_target, i_fencei_valid, i_fencei_pc,
               i_pipe_empty, i_icache_inv_done,
        output o_trap_taken, o_mret_taken, o_trap_target, o_branch_taken,
               o_branch_target, o_flush, o_icache_inv, o_fencei_ack, o_busy
    );

    modport master (
        output i_stall, i_trap_req, i_mret_req, i_trap_target,
               i_branch_req, i_branch_target, i_fencei_valid, i_fencei_pc,
               i_pipe_empty, i_icache_inv_done,
        input  o_trap_taken, o_mret_taken, o_trap_target, o_branch_taken,
               o_branch_target, o_flush, o_icache_inv, o_fencei_ack, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/redirect_sequencer_flush.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flush_window_counter                                       |
// | Description : 3-bit down counter defining the flush window after an      |
// |               issued redirect. A load restarts the window even if one    |
// |               is already running.                                        |
// | Ports       : i_clk     - clock                                          |
// |               i_rst_n   - synchronous active-low reset                   |
// |               i_load    - reload to LOAD_VAL                             |
// |               o_active  - window active (count != 0)                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module flush_window_counter
    import redirect_sequencer_pkg::*;
#(
    parameter int LOAD_VAL = 2   // legal range 1..7
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_load,
    output logic      o_active
);

    localparam logic [c_FLUSH_CNT_W-1:0] c_LOAD = c_FLUSH_CNT_W'(LOAD_VAL);

    logic [c_FLUSH_CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_LOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_active = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/redirect_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : redirect_sequencer                                         |
// | Description : Single owner of IF-stage PC redirects. Arbitrates trap >   |
// |               mret > branch > FENCE.I, holds a redirect across stalls,   |
// |               opens a flush window after every issued redirect and       |
// |               sequences FENCE.I (drain, I-cache invalidate, refetch).    |
// | Ports       : i_clk   - clock                                            |
// |               i_rst_n - synchronous active-low reset                     |
// |               bus     - redirect_sequencer_if.slave (requests in,        |
// |                         issue strobes/targets/flush/ack/busy out)        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module redirect_sequencer
    import redirect_sequencer_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    redirect_sequencer_if.slave bus
);

    redir_state_e   r_state;
    redirect_kind_e r_hold_kind;
    logic [XLEN-1:0] r_hold_tgt;
    logic            r_icache_inv;

    redir_state_e    w_next_state;
    redirect_kind_e  w_new_kind;
    logic [XLEN-1:0] w_new_tgt;
    logic            w_new_trap;
    redirect_kind_e  w_issue_kind;
    logic [XLEN-1:0] w_issue_tgt;
    logic            w_cap;
    redirect_kind_e  w_cap_kind;
    logic [XLEN-1:0] w_cap_tgt;
    logic            w_set_inv;
    logic            w_fencei_ack;
    logic            w_issue;
    logic            w_flush_active;

    // Same-cycle priority among the pulse sources; the losers are dropped.
    always_comb begin
        w_new_kind = K_NONE;
        w_new_tgt  = '0;
        if (bus.i_trap_req) begin
            w_new_kind = K_TRAP;
            w_new_tgt  = bus.i_trap_target;
        end else if (bus.i_mret_req) begin
            w_new_kind = K_MRET;
            w_new_tgt  = bus.i_trap_target;
        end else if (bus.i_branch_req) begin
            w_new_kind = K_BRANCH;
            w_new_tgt  = bus.i_branch_target;
        end
    end

    assign w_new_trap = is_trap_kind(w_new_kind);

    // Next-state and issue decode. Issue is combinational so a redirect in
    // IDLE (or a replay in the cycle the stall drops) costs no latency.
    always_comb begin
        w_next_state = r_state;
        w_issue_kind = K_NONE;
        w_issue_tgt  = '0;
        w_cap        = 1'b0;
        w_cap_kind   = K_NONE;
        w_cap_tgt    = '0;
        w_set_inv    = 1'b0;
        w_fencei_ack = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_new_kind != K_NONE) begin
                    if (!bus.i_stall) begin
                        w_issue_kind = w_new_kind;
                        w_issue_tgt  = w_new_tgt;
                    end else begin
                        w_cap        = 1'b1;
                        w_cap_kind   = w_new_kind;
                        w_cap_tgt    = w_new_tgt;
                        w_next_state = S_HOLD;
                    end
                end else if (bus.i_fencei_valid && !w_flush_active) begin
                    w_next_state = S_FENCE_DRAIN;
                end
            end
            S_HOLD: begin
                // Only a trap-class request may displace a held branch; a
                // held trap/mret is never displaced (it is the older one).
                w_cap_kind = r_hold_kind;
                w_cap_tgt  = r_hold_tgt;
                if (w_new_trap && !is_trap_kind(r_hold_kind)) begin
                    w_cap_kind = w_new_kind;
                    w_cap_tgt  = w_new_tgt;
                end
                if (!bus.i_stall) begin
                    w_issue_kind = w_cap_kind;
                    w_issue_tgt  = w_cap_tgt;
                    w_next_state = S_IDLE;
                end else begin
                    w_cap = 1'b1;
                end
            end
            default: begin
                // Any FENCE_* state: trap/mret aborts the fence without ack,
                // branches are ignored.
                if (w_new_trap) begin
                    if (!bus.i_stall) begin
                        w_issue_kind = w_new_kind;
                        w_issue_tgt  = w_new_tgt;
                        w_next_state = S_IDLE;
                    end else begin
                        w_cap        = 1'b1;
                        w_cap_kind   = w_new_kind;
                        w_cap_tgt    = w_new_tgt;
                        w_next_state = S_HOLD;
                    end
                end else begin
                    case (r_state)
                        S_FENCE_DRAIN: begin
                            if (bus.i_pipe_empty) begin
                                w_next_state = S_FENCE_INV;
                                w_set_inv    = 1'b1;
                            end
                        end
                        S_FENCE_INV: begin
                            if (bus.i_icache_inv_done) begin
                                w_next_state = S_FENCE_REDIR;
                            end
                        end
                        S_FENCE_REDIR: begin
                            if (!bus.i_stall) begin
                                w_issue_kind = K_FENCE;
                                w_issue_tgt  = bus.i_fencei_pc + XLEN'(4);
                                w_fencei_ack = 1'b1;
                                w_next_state = S_IDLE;
                            end
                        end
                        default: begin
                            w_next_state = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    assign w_issue = (w_issue_kind != K_NONE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_hold_kind  <= K_NONE;
            r_hold_tgt   <= '0;
            r_icache_inv <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_icache_inv <= w_set_inv;
            if (w_cap) begin
                r_hold_kind <= w_cap_kind;
                r_hold_tgt  <= w_cap_tgt;
            end else if (w_issue) begin
                r_hold_kind <= K_NONE;
                r_hold_tgt  <= '0;
            end
        end
    end

    flush_window_counter #(
        .LOAD_VAL (FLUSH_CYCLES)
    ) u_flush_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_issue),
        .o_active (w_flush_active)
    );

    assign bus.o_trap_taken    = (w_issue_kind == K_TRAP);
    assign bus.o_mret_taken    = (w_issue_kind == K_MRET);
    assign bus.o_trap_target   = is_trap_kind(w_issue_kind) ? w_issue_tgt : '0;
    assign bus.o_branch_taken  = (w_issue_kind == K_BRANCH) || (w_issue_kind == K_FENCE);
    assign bus.o_branch_target = bus.o_branch_taken ? w_issue_tgt : '0;
    assign bus.o_flush         = w_flush_active;
    assign bus.o_icache_inv    = r_icache_inv;
    assign bus.o_fencei_ack    = w_fencei_ack;
    assign bus.o_busy          = (r_state != S_IDLE) || w_flush_active;

endmodule
`default_nettype wire

// File: tb/tb_redirect_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_redirect_sequencer                                      |
// | Description : Directed self-checking bench for redirect_sequencer.       |
// |               Output strobes are compared as a 7-bit vector:             |
// |               {trap, mret, branch, flush, icache_inv, fencei_ack, busy}. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_redirect_sequencer;

    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    redirect_sequencer_if #(.XLEN(XLEN)) bus ();

    redirect_sequencer #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.o_trap_taken, bus.o_mret_taken, bus.o_branch_taken, bus.o_flush,
                bus.o_icache_inv, bus.o_fencei_ack, bus.o_busy};
    endfunction

    // Inputs change at posedge+1; comparisons happen a little later in the cycle.
    task automatic chk_o(input string tag, input logic [6:0] exp);
        #1;
        check(tag, {25'd0, outs()}, {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulses();
        bus.i_trap_req        = 1'b0;
        bus.i_mret_req        = 1'b0;
        bus.i_branch_req      = 1'b0;
        bus.i_icache_inv_done = 1'b0;
        bus.i_pipe_empty      = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clr_pulses();
        bus.i_stall         = 1'b0;
        bus.i_trap_target   = '0;
        bus.i_branch_target = '0;
        bus.i_fencei_valid  = 1'b0;
        bus.i_fencei_pc     = '0;
        tick();
        tick();

        // Reset state
        chk_o("reset_outs", 7'b0000000);
        check("reset_trap_tgt", bus.o_trap_target, 32'h0);
        check("reset_br_tgt", bus.o_branch_target, 32'h0);
        rst_n = 1'b1;
        tick();

        // Branch pass-through, flush for exactly 2 cycles
        bus.i_branch_req = 1'b1; bus.i_branch_target = 32'h100;
        chk_o("br_issue", 7'b0010000);
        check("br_tgt", bus.o_branch_target, 32'h100);
        tick(); clr_pulses();
        chk_o("br_flush1", 7'b0001001);
        tick();
        chk_o("br_flush2", 7'b0001001);
        tick();
        chk_o("br_flush_end", 7'b0000000);

        // Trap and branch in the same cycle: trap only
        bus.i_trap_req = 1'b1; bus.i_trap_target = 32'h80;
        bus.i_branch_req = 1'b1; bus.i_branch_target = 32'h200;
        chk_o("trap_vs_br", 7'b1000000);
        check("trap_vs_br_tgt", bus.o_trap_target, 32'h80);
        tick(); clr_pulses();
        repeat (2) tick();

        // Held branch, trap arrives in stall cycle 2, issued on release
        bus.i_stall = 1'b1;
        bus.i_branch_req = 1'b1; bus.i_branch_target = 32'h300;
        chk_o("stall_c1", 7'b0000000);
        tick(); clr_pulses();
        bus.i_trap_req = 1'b1; bus.i_trap_target = 32'h80;
        chk_o("stall_c2", 7'b0000001);
        tick(); clr_pulses();
        chk_o("stall_c3", 7'b0000001);
        tick();
        bus.i_stall = 1'b0;
        chk_o("replay_trap", 7'b1000001);
        check("replay_trap_tgt", bus.o_trap_target, 32'h80);
        tick();
        chk_o("replay_flush", 7'b0001001);
        repeat (2) tick();

        // Held branch replayed as a branch
        bus.i_stall = 1'b1;
        bus.i_branch_req = 1'b1; bus.i_branch_target = 32'h400;
        tick(); clr_pulses();
        bus.i_stall = 1'b0;
        chk_o("replay_br", 7'b0010001);
        check("replay_br_tgt", bus.o_branch_target, 32'h400);
        tick();
        repeat (2) tick();

        // Held mret is not displaced by a branch arriving in the issue cycle
        bus.i_stall = 1'b1;
        bus.i_mret_req = 1'b1; bus.i_trap_target = 32'h90;
        tick(); clr_pulses();
        bus.i_stall = 1'b0;
        bus.i_branch_req = 1'b1; bus.i_branch_target = 32'h500;
        chk_o("held_mret", 7'b0100001);
        check("held_mret_tgt", bus.o_trap_target, 32'h90);
        tick(); clr_pulses();
        repeat (2) tick();

        // FENCE.I at 0x1000
        bus.i_fencei_valid = 1'b1; bus.i_fencei_pc = 32'h1000;
        chk_o("fence_accept", 7'b0000000);
        tick();
        chk_o("fence_drain1", 7'b0000001);
        tick(); tick();
        bus.i_branch_req = 1'b1; bus.i_branch_target = 32'h700;
        chk_o("fence_br_ignored", 7'b0000001);
        tick(); clr_pulses();
        bus.i_pipe_empty = 1'b1;
        chk_o("fence_drain4", 7'b0000001);
        tick(); clr_pulses();
        chk_o("fence_inv_pulse", 7'b0000101);
        tick();
        chk_o("fence_inv_wait", 7'b0000001);
        tick(); tick(); tick();
        bus.i_icache_inv_done = 1'b1;
        chk_o("fence_inv_done", 7'b0000001);
        tick(); clr_pulses();
        chk_o("fence_redir", 7'b0010011);
        check("fence_tgt", bus.o_branch_target, 32'h1004);
        tick();
        bus.i_fencei_valid = 1'b0;
        chk_o("fence_flush", 7'b0001001);
        repeat (2) tick();

        // Trap during FENCE_INV aborts without ack, fence re-accepted later
        bus.i_fencei_valid = 1'b1; bus.i_fencei_pc = 32'h2000;
        tick();
        bus.i_pipe_empty = 1'b1;
        tick(); clr_pulses();
        tick();
        bus.i_trap_req = 1'b1; bus.i_trap_target = 32'hC0;
        chk_o("abort_trap", 7'b1000001);
        check("abort_trap_tgt", bus.o_trap_target, 32'hC0);
        tick(); clr_pulses();
        chk_o("abort_flush1", 7'b0001001);
        tick();
        chk_o("abort_flush2", 7'b0001001);
        tick();
        chk_o("reaccept", 7'b0000000);
        tick();
        chk_o("reaccept_drain", 7'b0000001);
        bus.i_pipe_empty = 1'b1;
        tick(); clr_pulses();
        chk_o("reaccept_inv", 7'b0000101);
        bus.i_icache_inv_done = 1'b1;
        tick(); clr_pulses();
        chk_o("reaccept_redir", 7'b0010011);
        check("reaccept_tgt", bus.o_branch_target, 32'h2004);
        tick();
        bus.i_fencei_valid = 1'b0;
        repeat (2) tick();

        // Reset while holding a redirect: nothing is replayed
        bus.i_stall = 1'b1;
        bus.i_branch_req = 1'b1; bus.i_branch_target = 32'h600;
        tick(); clr_pulses();
        chk_o("hold_busy", 7'b0000001);
        rst_n = 1'b0;
        tick();
        chk_o("rst_hold_outs", 7'b0000000);
        check("rst_hold_br_tgt", bus.o_branch_target, 32'h0);
        rst_n = 1'b1;
        bus.i_stall = 1'b0;
        chk_o("rst_no_replay", 7'b0000000);
        tick();
        chk_o("rst_no_flush", 7'b0000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
